// File: rtl/mc_ctrl_hs.sv
// mc_ctrl_hs: multicycle MIPS control FSM with memory handshake and
// wait timeout. Decodes Op/Funct and drives the datapath mux selects.
// Ports:
//   clk, rst (sync, active high), Zero, Op, Funct, mem_rdy
//   mem_req, RegWrite, MemWrite, PCWrite, IRWrite, IorD
//   EXTOp, ALUSrcA, ALUSrcB, ALUOp, PCSource, GPRSel, WDSel
//   illegal, bus_err, retire (single-cycle pulses)
module mc_ctrl_hs #(
    parameter int WAIT_EN  = 1,
    parameter int MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Zero,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       mem_rdy,
    output logic       mem_req,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       IorD,
    output logic [1:0] EXTOp,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [1:0] GPRSel,
    output logic [1:0] WDSel,
    output logic       illegal,
    output logic       bus_err,
    output logic       retire
);

    localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    localparam logic [3:0] A_ADD  = 4'd1;
    localparam logic [3:0] A_SUB  = 4'd2;
    localparam logic [3:0] A_AND  = 4'd3;
    localparam logic [3:0] A_OR   = 4'd4;
    localparam logic [3:0] A_SLT  = 4'd5;
    localparam logic [3:0] A_SLTU = 4'd6;
    localparam logic [3:0] A_NOR  = 4'd7;
    localparam logic [3:0] A_XOR  = 4'd8;
    localparam logic [3:0] A_SLL  = 4'd9;
    localparam logic [3:0] A_SRL  = 4'd10;
    localparam logic [3:0] A_SRA  = 4'd11;
    localparam logic [3:0] A_LUI  = 4'd12;

    typedef enum logic [2:0] {
        S_IF, S_ID, S_EXE, S_MEM, S_WB
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_wcnt;

    logic       w_ready;
    logic       w_tmo;
    logic       w_is_r, w_is_sh, w_is_jr, w_is_j, w_is_jal;
    logic       w_is_beq, w_is_bne, w_is_lw, w_is_sw, w_is_imm;
    logic       w_legal;
    logic [3:0] w_aop;
    logic [1:0] w_ext;

    assign w_ready = (WAIT_EN == 0) ? 1'b1 : mem_rdy;
    // Counter at the limit with memory still busy aborts the access;
    // a ready on the same cycle takes priority.
    assign w_tmo = (MAX_WAIT > 0) && (r_wcnt == CW'(MAX_WAIT)) && !w_ready;

    always_comb begin
        w_is_r   = 1'b0;
        w_is_sh  = 1'b0;
        w_is_jr  = 1'b0;
        w_is_j   = 1'b0;
        w_is_jal = 1'b0;
        w_is_beq = 1'b0;
        w_is_bne = 1'b0;
        w_is_lw  = 1'b0;
        w_is_sw  = 1'b0;
        w_is_imm = 1'b0;
        w_aop    = A_ADD;
        w_ext    = 2'd1;
        unique case (Op)
            6'h00: begin
                unique case (Funct)
                    6'h20, 6'h21: begin w_is_r = 1'b1; w_aop = A_ADD;  end
                    6'h22, 6'h23: begin w_is_r = 1'b1; w_aop = A_SUB;  end
                    6'h24:        begin w_is_r = 1'b1; w_aop = A_AND;  end
                    6'h25:        begin w_is_r = 1'b1; w_aop = A_OR;   end
                    6'h26:        begin w_is_r = 1'b1; w_aop = A_XOR;  end
                    6'h27:        begin w_is_r = 1'b1; w_aop = A_NOR;  end
                    6'h2A:        begin w_is_r = 1'b1; w_aop = A_SLT;  end
                    6'h2B:        begin w_is_r = 1'b1; w_aop = A_SLTU; end
                    6'h00:        begin w_is_sh = 1'b1; w_aop = A_SLL; end
                    6'h02:        begin w_is_sh = 1'b1; w_aop = A_SRL; end
                    6'h03:        begin w_is_sh = 1'b1; w_aop = A_SRA; end
                    6'h08:        w_is_jr = 1'b1;
                    default:      ;
                endcase
            end
            6'h02: w_is_j   = 1'b1;
            6'h03: w_is_jal = 1'b1;
            6'h04: w_is_beq = 1'b1;
            6'h05: w_is_bne = 1'b1;
            6'h08, 6'h09: begin w_is_imm = 1'b1; w_aop = A_ADD;  end
            6'h0A: begin w_is_imm = 1'b1; w_aop = A_SLT;  end
            6'h0B: begin w_is_imm = 1'b1; w_aop = A_SLTU; end
            6'h0C: begin w_is_imm = 1'b1; w_aop = A_AND; w_ext = 2'd0; end
            6'h0D: begin w_is_imm = 1'b1; w_aop = A_OR;  w_ext = 2'd0; end
            6'h0E: begin w_is_imm = 1'b1; w_aop = A_XOR; w_ext = 2'd0; end
            6'h0F: begin w_is_imm = 1'b1; w_aop = A_LUI; w_ext = 2'd2; end
            6'h23: w_is_lw = 1'b1;
            6'h2B: w_is_sw = 1'b1;
            default: ;
        endcase
    end

    assign w_legal = w_is_r | w_is_sh | w_is_jr | w_is_j | w_is_jal |
                     w_is_beq | w_is_bne | w_is_lw | w_is_sw | w_is_imm;

    always_comb begin
        w_next   = r_state;
        mem_req  = 1'b0;
        RegWrite = 1'b0;
        MemWrite = 1'b0;
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        IorD     = 1'b0;
        EXTOp    = 2'd1;
        ALUSrcA  = 2'd1;
        ALUSrcB  = 2'd0;
        ALUOp    = A_ADD;
        PCSource = 2'd0;
        GPRSel   = 2'd0;
        WDSel    = 2'd0;
        illegal  = 1'b0;
        bus_err  = 1'b0;
        retire   = 1'b0;
        unique case (r_state)
            S_IF: begin
                mem_req = 1'b1;
                ALUSrcA = 2'd0;
                ALUSrcB = 2'd1;
                if (w_tmo) begin
                    bus_err = 1'b1;
                    w_next  = S_IF;
                end else if (w_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    w_next  = S_ID;
                end
            end
            S_ID: begin
                if (w_is_j || w_is_jal) begin
                    PCSource = 2'd2;
                    PCWrite  = 1'b1;
                    retire   = 1'b1;
                    w_next   = S_IF;
                    if (w_is_jal) begin
                        RegWrite = 1'b1;
                        GPRSel   = 2'd2;
                        WDSel    = 2'd2;
                    end
                end else if (w_is_jr) begin
                    PCSource = 2'd3;
                    PCWrite  = 1'b1;
                    retire   = 1'b1;
                    w_next   = S_IF;
                end else if (!w_legal) begin
                    illegal = 1'b1;
                    w_next  = S_IF;
                end else begin
                    // Branch target is precomputed into ALUOut here.
                    ALUSrcA = 2'd0;
                    ALUSrcB = 2'd3;
                    w_next  = S_EXE;
                end
            end
            S_EXE: begin
                if (w_is_beq || w_is_bne) begin
                    ALUOp    = A_SUB;
                    PCSource = 2'd1;
                    PCWrite  = (w_is_beq & Zero) | (w_is_bne & ~Zero);
                    retire   = 1'b1;
                    w_next   = S_IF;
                end else if (w_is_lw || w_is_sw) begin
                    ALUSrcB = 2'd2;
                    w_next  = S_MEM;
                end else begin
                    ALUOp = w_aop;
                    if (w_is_sh) ALUSrcA = 2'd2;
                    if (w_is_imm) begin
                        ALUSrcB = 2'd2;
                        EXTOp   = w_ext;
                    end
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                IorD     = 1'b1;
                MemWrite = w_is_sw;
                if (w_tmo) begin
                    bus_err  = 1'b1;
                    MemWrite = 1'b0;
                    w_next   = S_IF;
                end else if (w_ready) begin
                    if (w_is_lw) begin
                        w_next = S_WB;
                    end else begin
                        retire = 1'b1;
                        w_next = S_IF;
                    end
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                GPRSel   = (w_is_imm | w_is_lw) ? 2'd1 : 2'd0;
                WDSel    = w_is_lw ? 2'd1 : 2'd0;
                retire   = 1'b1;
                w_next   = S_IF;
            end
            default: w_next = S_IF;
        endcase
        if (rst) begin
            mem_req  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            IorD     = 1'b0;
            EXTOp    = 2'd1;
            ALUSrcA  = 2'd1;
            ALUSrcB  = 2'd0;
            ALUOp    = A_ADD;
            PCSource = 2'd0;
            GPRSel   = 2'd0;
            WDSel    = 2'd0;
            illegal  = 1'b0;
            bus_err  = 1'b0;
            retire   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IF;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_next;
            // Timeout re-enters IF without a state change, so clear on it too.
            if (w_next != r_state || w_ready || w_tmo || !mem_req) begin
                r_wcnt <= '0;
            end else if (MAX_WAIT > 0) begin
                r_wcnt <= r_wcnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mc_ctrl_hs.sv
module tb_mc_ctrl_hs;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       Zero = 1'b0;
    logic       mem_rdy = 1'b0;
    logic [5:0] Op = 6'h00;
    logic [5:0] Funct = 6'h00;
    wire [24:0] o0;
    wire [24:0] o1;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mc_ctrl_hs #(.WAIT_EN(0), .MAX_WAIT(15)) u0 (
        .clk(clk), .rst(rst), .Zero(Zero), .Op(Op), .Funct(Funct),
        .mem_rdy(mem_rdy),
        .mem_req(o0[24]), .RegWrite(o0[23]), .MemWrite(o0[22]),
        .PCWrite(o0[21]), .IRWrite(o0[20]), .IorD(o0[19]),
        .EXTOp(o0[18:17]), .ALUSrcA(o0[16:15]), .ALUSrcB(o0[14:13]),
        .ALUOp(o0[12:9]), .PCSource(o0[8:7]), .GPRSel(o0[6:5]),
        .WDSel(o0[4:3]), .illegal(o0[2]), .bus_err(o0[1]),
        .retire(o0[0])
    );

    mc_ctrl_hs #(.WAIT_EN(1), .MAX_WAIT(15)) u1 (
        .clk(clk), .rst(rst), .Zero(Zero), .Op(Op), .Funct(Funct),
        .mem_rdy(mem_rdy),
        .mem_req(o1[24]), .RegWrite(o1[23]), .MemWrite(o1[22]),
        .PCWrite(o1[21]), .IRWrite(o1[20]), .IorD(o1[19]),
        .EXTOp(o1[18:17]), .ALUSrcA(o1[16:15]), .ALUSrcB(o1[14:13]),
        .ALUOp(o1[12:9]), .PCSource(o1[8:7]), .GPRSel(o1[6:5]),
        .WDSel(o1[4:3]), .illegal(o1[2]), .bus_err(o1[1]),
        .retire(o1[0])
    );

    // en = {mem_req, RegWrite, MemWrite, PCWrite, IRWrite, IorD}
    // p  = {illegal, bus_err, retire}
    function automatic logic [24:0] ov(
        input logic [5:0] en, input logic [1:0] ext,
        input logic [1:0] asa, input logic [1:0] asb,
        input logic [3:0] aop, input logic [1:0] pcs,
        input logic [1:0] gs, input logic [1:0] wd,
        input logic [2:0] p);
        return {en, ext, asa, asb, aop, pcs, gs, wd, p};
    endfunction

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [24:0] e;
    } vec_t;

    vec_t tv[$];

    logic [24:0] c_def, c_ifr, c_ifw, c_idn, c_memlw, c_memsw;

    task automatic chk(input string nm, input logic [24:0] got,
                       input logic [24:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic add(input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy,
                       input logic [24:0] e);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.e = e;
        tv.push_back(v);
    endtask

    task automatic cyc(input string nm, input bit sel,
                       input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy,
                       input logic [24:0] e);
        Op = op; Funct = fn; Zero = z; mem_rdy = rdy;
        @(negedge clk);
        chk(nm, sel ? o1 : o0, e);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input bit sel, input string tag);
        foreach (tv[i])
            cyc($sformatf("%s%0d", tag, i), sel,
                tv[i].op, tv[i].fn, tv[i].z, tv[i].rdy, tv[i].e);
        tv.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; Op = 6'h00; Funct = 6'h00; Zero = 1'b0; mem_rdy = 1'b0;
        @(negedge clk);
        chk("rst_u0", o0, c_def);
        chk("rst_u1", o1, c_def);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        c_def   = ov(6'b000000, 1, 1, 0, 1, 0, 0, 0, 3'b000);
        c_ifr   = ov(6'b100110, 1, 0, 1, 1, 0, 0, 0, 3'b000);
        c_ifw   = ov(6'b100000, 1, 0, 1, 1, 0, 0, 0, 3'b000);
        c_idn   = ov(6'b000000, 1, 0, 3, 1, 0, 0, 0, 3'b000);
        c_memlw = ov(6'b100001, 1, 1, 0, 1, 0, 0, 0, 3'b000);
        c_memsw = ov(6'b101001, 1, 1, 0, 1, 0, 0, 0, 3'b000);

        do_reset();

        // WAIT_EN=0, mem_rdy held low: add(4) lw(5) sw(4)
        add(6'h00, 6'h20, 0, 0, c_ifr);
        add(6'h00, 6'h20, 0, 0, c_idn);
        add(6'h00, 6'h20, 0, 0, ov(0, 1, 1, 0, 1, 0, 0, 0, 3'b000));
        add(6'h00, 6'h20, 0, 0, ov(6'b010000, 1, 1, 0, 1, 0, 0, 0, 3'b001));
        add(6'h23, 6'h00, 0, 0, c_ifr);
        add(6'h23, 6'h00, 0, 0, c_idn);
        add(6'h23, 6'h00, 0, 0, ov(0, 1, 1, 2, 1, 0, 0, 0, 3'b000));
        add(6'h23, 6'h00, 0, 0, c_memlw);
        add(6'h23, 6'h00, 0, 0, ov(6'b010000, 1, 1, 0, 1, 0, 1, 1, 3'b001));
        add(6'h2B, 6'h00, 0, 0, c_ifr);
        add(6'h2B, 6'h00, 0, 0, c_idn);
        add(6'h2B, 6'h00, 0, 0, ov(0, 1, 1, 2, 1, 0, 0, 0, 3'b000));
        add(6'h2B, 6'h00, 0, 0, ov(6'b101001, 1, 1, 0, 1, 0, 0, 0, 3'b001));
        run(0, "nowait");

        do_reset();

        // WAIT_EN=1: IF stall then jr
        for (int k = 0; k < 3; k++) add(6'h00, 6'h08, 0, 0, c_ifw);
        add(6'h00, 6'h08, 0, 1, c_ifr);
        add(6'h00, 6'h08, 0, 0, ov(6'b000100, 1, 1, 0, 1, 3, 0, 0, 3'b001));
        // jal
        add(6'h03, 6'h00, 0, 1, c_ifr);
        add(6'h03, 6'h00, 0, 0, ov(6'b010100, 1, 1, 0, 1, 2, 2, 2, 3'b001));
        // sll
        add(6'h00, 6'h00, 0, 1, c_ifr);
        add(6'h00, 6'h00, 0, 0, c_idn);
        add(6'h00, 6'h00, 0, 0, ov(0, 1, 2, 0, 9, 0, 0, 0, 3'b000));
        add(6'h00, 6'h00, 0, 0, ov(6'b010000, 1, 1, 0, 1, 0, 0, 0, 3'b001));
        // lui
        add(6'h0F, 6'h00, 0, 1, c_ifr);
        add(6'h0F, 6'h00, 0, 0, c_idn);
        add(6'h0F, 6'h00, 0, 0, ov(0, 2, 1, 2, 12, 0, 0, 0, 3'b000));
        add(6'h0F, 6'h00, 0, 0, ov(6'b010000, 1, 1, 0, 1, 0, 1, 0, 3'b001));
        // illegal opcode
        add(6'h3F, 6'h00, 0, 1, c_ifr);
        add(6'h3F, 6'h00, 0, 0, ov(0, 1, 1, 0, 1, 0, 0, 0, 3'b100));
        // bne taken with Zero=0
        add(6'h05, 6'h00, 0, 1, c_ifr);
        add(6'h05, 6'h00, 0, 0, c_idn);
        add(6'h05, 6'h00, 0, 0, ov(6'b000100, 1, 1, 0, 2, 1, 0, 0, 3'b001));
        // beq not taken with Zero=0
        add(6'h04, 6'h00, 0, 1, c_ifr);
        add(6'h04, 6'h00, 0, 0, c_idn);
        add(6'h04, 6'h00, 0, 0, ov(0, 1, 1, 0, 2, 1, 0, 0, 3'b001));
        // lw with 3 MEM wait cycles
        add(6'h23, 6'h00, 0, 1, c_ifr);
        add(6'h23, 6'h00, 0, 0, c_idn);
        add(6'h23, 6'h00, 0, 0, ov(0, 1, 1, 2, 1, 0, 0, 0, 3'b000));
        for (int k = 0; k < 3; k++) add(6'h23, 6'h00, 0, 0, c_memlw);
        add(6'h23, 6'h00, 0, 1, c_memlw);
        add(6'h23, 6'h00, 0, 0, ov(6'b010000, 1, 1, 0, 1, 0, 1, 1, 3'b001));
        add(6'h00, 6'h20, 0, 0, c_ifw);
        run(1, "wait");

        // sw timeout: 15 busy MEM cycles, bus_err on the 16th
        do_reset();
        cyc("sw_if", 1, 6'h2B, 0, 0, 1, c_ifr);
        cyc("sw_id", 1, 6'h2B, 0, 0, 0, c_idn);
        cyc("sw_exe", 1, 6'h2B, 0, 0, 0, ov(0, 1, 1, 2, 1, 0, 0, 0, 3'b000));
        for (int k = 1; k <= 15; k++)
            cyc($sformatf("sw_mem%0d", k), 1, 6'h2B, 0, 0, 0, c_memsw);
        cyc("sw_tmo", 1, 6'h2B, 0, 0, 0,
            ov(6'b100001, 1, 1, 0, 1, 0, 0, 0, 3'b010));
        cyc("sw_refetch", 1, 6'h00, 6'h20, 0, 1, c_ifr);

        // ready on the limit cycle completes normally
        do_reset();
        cyc("lim_if", 1, 6'h23, 0, 0, 1, c_ifr);
        cyc("lim_id", 1, 6'h23, 0, 0, 0, c_idn);
        cyc("lim_exe", 1, 6'h23, 0, 0, 0, ov(0, 1, 1, 2, 1, 0, 0, 0, 3'b000));
        for (int k = 1; k <= 15; k++)
            cyc($sformatf("lim_mem%0d", k), 1, 6'h23, 0, 0, 0, c_memlw);
        cyc("lim_rdy", 1, 6'h23, 0, 0, 1, c_memlw);
        cyc("lim_wb", 1, 6'h23, 0, 0, 0,
            ov(6'b010000, 1, 1, 0, 1, 0, 1, 1, 3'b001));

        // reset during MEM wait of lw, then IF timeout from a clear counter
        do_reset();
        cyc("rm_if", 1, 6'h23, 0, 0, 1, c_ifr);
        cyc("rm_id", 1, 6'h23, 0, 0, 0, c_idn);
        cyc("rm_exe", 1, 6'h23, 0, 0, 0, ov(0, 1, 1, 2, 1, 0, 0, 0, 3'b000));
        cyc("rm_mem1", 1, 6'h23, 0, 0, 0, c_memlw);
        cyc("rm_mem2", 1, 6'h23, 0, 0, 0, c_memlw);
        rst = 1'b1;
        cyc("rm_rst", 1, 6'h23, 0, 0, 0, c_def);
        rst = 1'b0;
        for (int k = 1; k <= 15; k++)
            cyc($sformatf("rm_ifw%0d", k), 1, 6'h23, 0, 0, 0, c_ifw);
        cyc("rm_iftmo", 1, 6'h23, 0, 0, 0,
            ov(6'b100000, 1, 0, 1, 1, 0, 0, 0, 3'b010));
        cyc("rm_ifw_after", 1, 6'h23, 0, 0, 0, c_ifw);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_hs.md
Name: mc_ctrl_hs

Overview:
- Next-generation multicycle MIPS control FSM.
- Adds a memory request/ready handshake with optional wait states and a bounded wait timeout.
- Extends the instruction set: shifts, jr, andi/xori/lui/slti/addiu, and a working bne.
- Adds illegal-opcode detection and an instruction-retire pulse.
- Drives the same multicycle datapath mux/enable points as before, with widened selects.

Parameters:
- WAIT_EN, 1, 1 = honour mem_rdy; 0 = memory always ready (mem_rdy ignored, single-cycle access).
- MAX_WAIT, 15, max consecutive not-ready cycles per access before abort; 0 = unbounded wait.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- Zero  in  1  ALU zero flag
- Op  in  6  opcode from IR
- Funct  in  6  funct from IR
- mem_rdy  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request
- RegWrite  out  1  register file write enable
- MemWrite  out  1  memory write (qualified by mem_req)
- PCWrite  out  1  PC write enable
- IRWrite  out  1  IR write enable
- IorD  out  1  0 = instruction address (PC), 1 = data address (ALUOut)
- EXTOp  out  2  0 = zero-ext, 1 = sign-ext, 2 = imm<<16 (lui)
- ALUSrcA  out  2  0 = PC, 1 = rs, 2 = shamt zero-extended
- ALUSrcB  out  2  0 = rt, 1 = 4, 2 = ext imm, 3 = branch offset
- ALUOp  out  4  0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 SLT, 6 SLTU, 7 NOR, 8 XOR, 9 SLL, 10 SRL, 11 SRA, 12 LUI(pass B)
- PCSource  out  2  0 = ALU, 1 = ALUOut, 2 = jump target, 3 = rs (jr)
- GPRSel  out  2  0 = rd, 1 = rt, 2 = $31
- WDSel  out  2  0 = ALU, 1 = MEM, 2 = PC
- illegal  out  1  one-cycle pulse in ID on an undecoded instruction
- bus_err  out  1  one-cycle pulse on wait timeout
- retire  out  1  one-cycle pulse on the final cycle of each completed instruction

Behaviour:
- Reset: synchronous; state <= IF and wait counter <= 0. While rst = 1, all enables, mem_req, illegal, bus_err and retire are forced 0; selects take their defaults (ALUSrcA = 1, ALUSrcB = 0, ALUOp = ADD, EXTOp = 1, others 0). Reset mid-access abandons the access with no writes.
- Outputs are combinational from state and decode (Moore/Mealy as stated below). The state and wait counter are the only registers.
- States: IF, ID, EXE, MEM, WB.
- IF: mem_req = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 1, ADD. Stay in IF until ready (ready = mem_rdy | ~WAIT_EN). On ready: IRWrite = 1, PCWrite = 1, go to ID.
- ID:
  - j: PCSource = 2, PCWrite, retire -> IF.
  - jal: additionally RegWrite, GPRSel = 2, WDSel = 2.
  - jr (R, funct 001000): PCSource = 3, PCWrite, retire -> IF.
  - Undecoded: illegal = 1, retire = 0, no writes -> IF.
  - Otherwise: ALUSrcA = 0, ALUSrcB = 3, ADD (branch target into ALUOut) -> EXE.
- EXE:
  - beq/bne: ALUSrcA = 1, ALUSrcB = 0, SUB, PCSource = 1. PCWrite = (beq & Zero) | (bne & ~Zero). Retire -> IF.
  - lw/sw: ADD, ALUSrcB = 2, EXTOp = 1 -> MEM.
  - Shifts sll/srl/sra: ALUSrcA = 2, ALUSrcB = 0.
  - I-type ALU ops: ALUSrcB = 2. EXTOp = 0 for andi/ori/xori, 2 for lui, 1 otherwise.
  - Then -> WB.
- MEM: mem_req = 1, IorD = 1, MemWrite = sw. Stay until ready. On ready: lw -> WB; sw -> retire, IF.
- WB: RegWrite = 1. GPRSel = 1 for I-type, else 0. WDSel = 1 for lw. Retire -> IF.
- Wait counter (width clog2(MAX_WAIT+1)):
  - Increments each cycle mem_req = 1 and not ready; clears on ready or on any state change.
  - If MAX_WAIT > 0 and the counter equals MAX_WAIT while still not ready: bus_err = 1, no IRWrite/PCWrite/MemWrite/RegWrite, -> IF (re-fetch from the unchanged PC).
  - mem_rdy on the same cycle as the limit wins: normal completion, no bus_err.
- mem_rdy outside IF/MEM is ignored.
- MemWrite is asserted on every MEM cycle of a sw; memory samples it only with mem_rdy.

Test Plan:
- WAIT_EN = 0: add, then lw, then sw -> 4, 5, 4 cycles respectively. retire pulses on cycles 4, 9, 13. WB of lw shows WDSel = 1, GPRSel = 1.
- WAIT_EN = 1, mem_rdy low 3 cycles in IF -> IRWrite/PCWrite only on cycle 4, mem_req held high throughout. Same check in MEM for lw.
- MAX_WAIT = 15, mem_rdy never asserted in MEM of sw -> bus_err on the 16th MEM cycle (counter = 15), then IF, no RegWrite.
- bne with Zero = 0 -> PCWrite = 1, PCSource = 1 in EXE. beq with Zero = 0 -> PCWrite = 0, retire = 1.
- jr, jal, sll, lui, and Op = 6'h3F:
  - jr -> PCSource = 3.
  - jal -> GPRSel = 2, WDSel = 2, RegWrite.
  - sll -> ALUSrcA = 2, ALUOp = 9.
  - lui -> EXTOp = 2, ALUOp = 12.
  - Op = 6'h3F -> illegal pulse, back to IF.
- rst = 1 asserted during MEM wait -> next cycle in IF, counter 0, no MemWrite at any point.
